instr_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute sequencer for the 8-bit processor. It is the producer side of the accumulator-control interface.
- Fetches instruction bytes over a request/ready memory handshake, decodes them, and drives one-cycle control strobes into accontrol: jump, jumpC, sin, InA, twone.
- Owns the program counter and the instruction register.

---
 rtl/seq_pkg.sv | 29 ++
 rtl/instr_sequencer_if.sv | 17 +
 rtl/opcode_decoder.sv | 37 +++
 rtl/instr_sequencer.sv | 115 +++++++++++
 tb/tb_instr_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer.
//   - FSM state encoding (legacy-compatible 2-bit constants)
//   - Opcode constants carried in instruction byte [7:4]
//   - strobe_t: the control strobe bundle driven into accontrol
package seq_pkg;

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_HALT   = 2'd3;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_ADDR = 4'h3;
  localparam logic [3:0] OP_MOVR = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JC   = 4'h6;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef struct packed {
    logic jump;
    logic jump_c;
    logic sin;
    logic in_a;
    logic twone;
  } strobe_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-fetch bus between the sequencer and instruction memory.
//   mem_rd    : fetch request (sequencer -> memory)
//   mem_addr  : fetch address (sequencer -> memory)
//   mem_ready : data valid on mem_data this cycle (memory -> sequencer)
//   mem_data  : instruction byte, opcode [7:4], operand [3:0]
// master = sequencer side, slave = memory side.
interface instr_sequencer_if #(
  parameter int PC_W = 8
);
  logic            mem_rd;
  logic [PC_W-1:0] mem_addr;
  logic            mem_ready;
  logic [7:0]      mem_data;

  modport master (output mem_rd, output mem_addr, input mem_ready, input mem_data);
  modport slave  (input mem_rd, input mem_addr, output mem_ready, output mem_data);
endinterface

// File: rtl/opcode_decoder.sv
// Purely combinational opcode -> control-strobe map.
//   opcode_i  : instruction opcode (ir[7:4])
//   strobe_o  : strobe bundle to present during EXEC
//   illegal_o : opcode 7..E (undefined, executes as NOP)
//   is_halt_o : opcode F
module opcode_decoder
  import seq_pkg::*;
(
  input  logic [3:0] opcode_i,
  output strobe_t    strobe_o,
  output logic       illegal_o,
  output logic       is_halt_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    strobe_o  = '0;
    illegal_o = 1'b0;
    is_halt_o = 1'b0;
    case (opcode_i)
      OP_NOP:  ;
      OP_LDA:  strobe_o.in_a   = 1'b1;
      OP_ADD:  strobe_o.sin    = 1'b1;
      OP_ADDR: begin
        strobe_o.sin   = 1'b1;
        strobe_o.twone = 1'b1;
      end
      OP_MOVR: strobe_o.twone  = 1'b1;
      OP_JMP:  strobe_o.jump   = 1'b1;
      OP_JC:   strobe_o.jump_c = 1'b1;
      OP_HLT:  is_halt_o = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit processor; producer side of
// the accumulator-control interface. Owns pc and the instruction register.
//   clk, rst_n : clock, synchronous active-low reset
//   mem        : instruction fetch bus (master modport)
//   carry      : datapath carry, sampled in EXEC for JC
//   jump, jumpC, sin, InA, twone : one-cycle strobes, high only in EXEC
//   halted     : high while in HALT
//   illegal    : one-cycle pulse in EXEC for an undefined opcode
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_sequencer_if.master   mem,
  input  logic                carry,
  output logic                jump,
  output logic                jumpC,
  output logic                sin,
  output logic                InA,
  output logic                twone,
  output logic                halted,
  output logic                illegal
);

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  strobe_t         strobe_q, strobe_d;
  logic            illegal_q, illegal_d;

  strobe_t         dec_strobe;
  logic            dec_illegal;
  logic            dec_halt;
  logic            fetch_accept;
  logic [PC_W-1:0] jump_target;

  opcode_decoder u_decoder (
    .opcode_i  (ir_q[7:4]),
    .strobe_o  (dec_strobe),
    .illegal_o (dec_illegal),
    .is_halt_o (dec_halt)
  );

  // The request is masked during the reset cycle itself so memory never sees
  // a fetch that the reset is about to discard.
  assign mem.mem_rd   = (state_q == ST_FETCH) && rst_n;
  assign mem.mem_addr = pc_q;
  assign fetch_accept = mem.mem_rd && mem.mem_ready;
  assign jump_target  = PC_W'(ir_q[3:0]);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    strobe_d  = '0;
    illegal_d = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (fetch_accept) begin
          ir_d    = mem.mem_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Strobes are registered here so they appear glitch-free for
        // exactly the EXEC cycle and are cleared on leaving it.
        if (dec_halt) begin
          state_d = ST_HALT;
        end else begin
          state_d   = ST_EXEC;
          strobe_d  = dec_strobe;
          illegal_d = dec_illegal;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        if ((ir_q[7:4] == OP_JMP) || ((ir_q[7:4] == OP_JC) && carry)) begin
          pc_d = jump_target;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 8'h00;
      strobe_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      strobe_q  <= strobe_d;
      illegal_q <= illegal_d;
    end
  end

  assign jump    = strobe_q.jump;
  assign jumpC   = strobe_q.jump_c;
  assign sin     = strobe_q.sin;
  assign InA     = strobe_q.in_a;
  assign twone   = strobe_q.twone;
  assign halted  = (state_q == ST_HALT);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios with literal
// expectations, then randomized instruction streams checked every cycle
// against an instruction-level reference model.
module tb_instr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic carry;
  logic jump, jumpC, sin, InA, twone, halted, illegal;

  instr_sequencer_if #(.PC_W(8)) bus ();

  instr_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mem     (bus),
    .carry   (carry),
    .jump    (jump),
    .jumpC   (jumpC),
    .sin     (sin),
    .InA     (InA),
    .twone   (twone),
    .halted  (halted),
    .illegal (illegal)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: where we are within the current instruction.
  //   m_slot 0 = waiting for the fetch to be accepted
  //   m_slot 1 = first cycle after acceptance (decode, nothing visible)
  //   m_slot 2 = second cycle after acceptance (strobes visible)
  //   m_slot 3 = halted until reset
  bit         m_valid = 1'b0;
  int         m_slot  = 0;
  logic [7:0] m_ir    = 8'h00;
  logic [7:0] m_pc    = 8'h00;

  // Snapshot of DUT outputs at the most recent negedge.
  logic       s_rd, s_halt, s_ill;
  logic [7:0] s_addr;
  logic [4:0] s_strb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // {jump, jumpC, sin, InA, twone} straight from the opcode table.
  function automatic logic [4:0] spec_strobes(input logic [3:0] op);
    case (op)
      4'h1:    return 5'b00010;
      4'h2:    return 5'b00100;
      4'h3:    return 5'b00101;
      4'h4:    return 5'b00001;
      4'h5:    return 5'b10000;
      4'h6:    return 5'b01000;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic compare_now();
    logic       exp_rd;
    logic [3:0] op;
    op = m_ir[7:4];
    s_rd   = bus.mem_rd;
    s_addr = bus.mem_addr;
    s_strb = {jump, jumpC, sin, InA, twone};
    s_halt = halted;
    s_ill  = illegal;
    if (m_valid) begin
      exp_rd = (m_slot == 0) && rst_n;
      check("mem_rd", 32'(s_rd), 32'(exp_rd));
      if (exp_rd) check("mem_addr", 32'(s_addr), 32'(m_pc));
      check("strobes", 32'(s_strb), (m_slot == 2) ? 32'(spec_strobes(op)) : 32'd0);
      check("halted", 32'(s_halt), 32'(m_slot == 3));
      check("illegal", 32'(s_ill), 32'((m_slot == 2) && (op >= 4'h7) && (op <= 4'hE)));
    end
  endtask

  task automatic model_update(input logic r, input logic rdy, input logic [7:0] data, input logic c);
    if (!r) begin
      m_valid = 1'b1;
      m_slot  = 0;
      m_pc    = 8'h00;
      m_ir    = 8'h00;
    end else if (m_valid) begin
      case (m_slot)
        0: if (rdy) begin
          m_ir   = data;
          m_pc   = m_pc + 8'd1;
          m_slot = 1;
        end
        1: m_slot = (m_ir[7:4] == 4'hF) ? 3 : 2;
        2: begin
          if ((m_ir[7:4] == 4'h5) || ((m_ir[7:4] == 4'h6) && c)) m_pc = {4'h0, m_ir[3:0]};
          m_slot = 0;
        end
        default: ;
      endcase
    end
  endtask

  // One clock: drive inputs, compare at negedge, advance model at posedge.
  task automatic step(input logic r, input logic rdy, input logic [7:0] data, input logic c);
    rst_n         = r;
    bus.mem_ready = rdy;
    bus.mem_data  = data;
    carry         = c;
    @(negedge clk);
    compare_now();
    @(posedge clk);
    model_update(r, rdy, data, c);
    #1;
  endtask

  // Fetch (after some wait states), decode, execute. The last snapshot left
  // behind is the execute cycle (or the first HALT cycle for HLT).
  task automatic do_instr(input logic [7:0] b, input int waits, input logic c);
    for (int i = 0; i < waits; i++) step(1'b1, 1'b0, 8'($urandom), c);
    step(1'b1, 1'b1, b, c);
    step(1'b1, 1'($urandom), 8'($urandom), c);
    step(1'b1, 1'($urandom), 8'($urandom), c);
  endtask

  initial begin
    rst_n         = 1'b0;
    carry         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_data  = 8'h00;

    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h20, 1'b0);
    check("reset_rd_low", 32'(bus.mem_rd), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_strobes", 32'({jump, jumpC, sin, InA, twone, illegal}), 32'd0);

    // ADD with zero wait states: sin appears two cycles after acceptance.
    step(1'b1, 1'b1, 8'h20, 1'b0);
    check("add_fetch_rd", 32'(s_rd), 32'd1);
    check("add_fetch_addr", 32'(s_addr), 32'h00);
    step(1'b1, 1'b1, 8'h20, 1'b0);
    check("add_decode_quiet", 32'(s_strb), 32'd0);
    check("add_decode_rd", 32'(s_rd), 32'd0);
    step(1'b1, 1'b0, 8'h20, 1'b0);
    check("add_exec_sin", 32'(s_strb), 32'b00100);
    check("add_model_pc", 32'(m_pc), 32'h01);
    check("add_next_addr", 32'(bus.mem_addr), 32'h01);
    check("add_next_rd", 32'(bus.mem_rd), 32'd1);

    do_instr(8'h10, 3, 1'b0);
    check("lda_ina", 32'(s_strb), 32'b00010);
    check("lda_next_addr", 32'(bus.mem_addr), 32'h02);

    do_instr(8'h56, 0, 1'b0);
    check("jmp_strobe", 32'(s_strb), 32'b10000);
    check("jmp_next_addr", 32'(bus.mem_addr), 32'h06);

    do_instr(8'h69, 0, 1'b0);
    check("jc_nc_strobe", 32'(s_strb), 32'b01000);
    check("jc_nc_next_addr", 32'(bus.mem_addr), 32'h07);

    do_instr(8'h69, 0, 1'b1);
    check("jc_c_strobe", 32'(s_strb), 32'b01000);
    check("jc_c_next_addr", 32'(bus.mem_addr), 32'h09);

    do_instr(8'h30, 1, 1'b0);
    check("addr_strobes", 32'(s_strb), 32'b00101);

    do_instr(8'h80, 0, 1'b0);
    check("undef_illegal", 32'(s_ill), 32'd1);
    check("undef_no_strobe", 32'(s_strb), 32'd0);
    check("undef_next_addr", 32'(bus.mem_addr), 32'h0B);

    do_instr(8'hF0, 0, 1'b0);
    check("hlt_halted", 32'(s_halt), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'($urandom), 8'($urandom), 1'($urandom));
      check("hlt_stays", 32'({s_halt, s_rd, s_strb}), 32'b1_0_00000);
    end
    check("hlt_pc_held", 32'(bus.mem_addr), 32'h0C);

    step(1'b0, 1'b1, 8'h20, 1'b0);
    check("hlt_reset_halted", 32'(halted), 32'd0);
    check("hlt_reset_addr", 32'(bus.mem_addr), 32'h00);

    // Reset during a fetch wait: the offered byte must not be taken.
    do_instr(8'h10, 0, 1'b0);
    step(1'b1, 1'b0, 8'h56, 1'b0);
    step(1'b1, 1'b0, 8'h56, 1'b0);
    step(1'b0, 1'b1, 8'h56, 1'b0);
    check("fetch_abort_addr", 32'(bus.mem_addr), 32'h00);
    do_instr(8'h20, 0, 1'b0);
    check("after_abort_sin", 32'(s_strb), 32'b00100);
    check("after_abort_addr", 32'(bus.mem_addr), 32'h01);

    // Randomized instruction streams with random waits, carry and resets.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if ((b[7:4] == 4'hF) && ($urandom_range(0, 3) != 0)) b[7:4] = 4'($urandom_range(0, 14));
      for (int w = $urandom_range(0, 2); w > 0; w--) begin
        step(($urandom_range(0, 30) != 0), 1'b0, 8'($urandom), 1'($urandom));
      end
      step(1'b1, 1'b1, b, 1'($urandom));
      step(1'b1, 1'($urandom), 8'($urandom), 1'($urandom));
      step(1'b1, 1'($urandom), 8'($urandom), 1'($urandom));
      if (m_slot == 3) begin
        for (int h = $urandom_range(1, 4); h > 0; h--) step(1'b1, 1'($urandom), 8'($urandom), 1'($urandom));
        step(1'b0, 1'($urandom), 8'($urandom), 1'($urandom));
      end else if ($urandom_range(0, 25) == 0) begin
        step(1'b0, 1'($urandom), 8'($urandom), 1'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
